// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of the memory arbiter.
interface mem_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic        ls_req_we;
    logic [1:0]  ls_req_size;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [1:0]  mem_wr;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  ls_req_valid, ls_req_we, ls_req_size, ls_req_addr, ls_req_wdata,
        input  mem_rd_data,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );
    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output ls_req_valid, ls_req_we, ls_req_size, ls_req_addr, ls_req_wdata,
        output mem_rd_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one read port between fetch and loads (loads favoured, fetch
// anti-starvation after STARVE_LIMIT losses); stores use the write port in parallel.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    logic [3:0] starve;
    logic       ld_valid, st_valid, fetch_win, if_acc, ld_acc, st_acc;
    logic       if_pend, ls_pend, ld_pend;
    assign st_valid  = bus.ls_req_valid && bus.ls_req_we;
    assign ld_valid  = bus.ls_req_valid && !bus.ls_req_we;
    assign fetch_win = bus.if_req_valid && (!ld_valid || starve == LIM);
    // acceptance is blocked while reset is asserted
    assign if_acc = rst_n && fetch_win;
    assign ld_acc = rst_n && ld_valid && !fetch_win;
    assign st_acc = rst_n && st_valid;
    assign bus.if_req_ready = if_acc;
    assign bus.ls_req_ready = ld_acc || st_acc;
    assign bus.mem_rd_addr  = ld_acc ? bus.ls_req_addr : bus.if_req_addr;
    assign bus.mem_wr       = st_acc ? bus.ls_req_size : 2'd0;
    assign bus.mem_wr_addr  = bus.ls_req_addr;
    assign bus.mem_wr_data  = bus.ls_req_wdata;
    assign bus.if_rsp_valid = if_pend && !bus.if_flush;
    assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rd_data : 32'd0;
    assign bus.ls_rsp_valid = ls_pend;
    assign bus.ls_rsp_data  = ld_pend ? bus.mem_rd_data : 32'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pend <= 1'b0;
            ls_pend <= 1'b0;
            ld_pend <= 1'b0;
            starve  <= 4'd0;
        end else begin
            if_pend <= if_acc;
            ls_pend <= ld_acc || st_acc;
            ld_pend <= ld_acc;
            starve  <= if_acc ? 4'd0
                     : (ld_acc && bus.if_req_valid && starve != LIM) ? starve + 4'd1
                     : starve;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, flush, store write-through and reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] mem [256];
    mem_arbiter_if bus ();
    mem_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // byte-addressed memory: one-cycle read, reads see contents before same-edge writes
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    end
    always @(posedge clk) begin
        bus.mem_rd_data <= {mem[bus.mem_rd_addr[7:0] + 8'd3], mem[bus.mem_rd_addr[7:0] + 8'd2],
                            mem[bus.mem_rd_addr[7:0] + 8'd1], mem[bus.mem_rd_addr[7:0]]};
        if (bus.mem_wr != 2'd0) mem[bus.mem_wr_addr[7:0]] <= bus.mem_wr_data[7:0];
        if (bus.mem_wr >= 2'd2) mem[bus.mem_wr_addr[7:0] + 8'd1] <= bus.mem_wr_data[15:8];
        if (bus.mem_wr == 2'd3) begin
            mem[bus.mem_wr_addr[7:0] + 8'd2] <= bus.mem_wr_data[23:16];
            mem[bus.mem_wr_addr[7:0] + 8'd3] <= bus.mem_wr_data[31:24];
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic fv, input logic [31:0] fa, input logic lv, input logic we,
                         input logic [1:0] sz, input logic [31:0] la, input logic [31:0] wd);
        bus.if_req_valid = fv; bus.if_req_addr = fa;
        bus.ls_req_valid = lv; bus.ls_req_we = we; bus.ls_req_size = sz;
        bus.ls_req_addr = la; bus.ls_req_wdata = wd;
    endtask
    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic contend();
        drive(1'b1, 32'h40, 1'b1, 1'b0, 2'd0, 32'h80, 32'd0);
    endtask
    initial begin
        bus.mem_rd_data = 32'd0;
        bus.if_flush = 1'b0;
        drive(1'b1, 32'h10, 1'b1, 1'b1, 2'd3, 32'h20, 32'h12345678);
        #3;
        chk("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
        chk("rst_ls_ready", 32'(bus.ls_req_ready), 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_if_rsp", 32'(bus.if_rsp_valid), 32'd0);
        chk("rst_ls_rsp", 32'(bus.ls_rsp_valid), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        drive(1'b1, 32'h10, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        #3;
        chk("f_ready", 32'(bus.if_req_ready), 32'd1);
        chk("f_ls_ready", 32'(bus.ls_req_ready), 32'd0);
        chk("f_rd_addr", bus.mem_rd_addr, 32'h10);
        tick(); idle(); #3;
        chk("f_rsp_valid", 32'(bus.if_rsp_valid), 32'd1);
        chk("f_rsp_data", bus.if_rsp_data, 32'h44332211);
        tick(); #3;
        chk("f_rsp_gone", 32'(bus.if_rsp_valid), 32'd0);
        chk("f_rsp_zero", bus.if_rsp_data, 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            logic el, pl;
            el = (i % 5) != 4;
            pl = ((i + 4) % 5) != 4;
            contend(); #3;
            chk($sformatf("arb%0d_ls_ready", i), 32'(bus.ls_req_ready), 32'(el));
            chk($sformatf("arb%0d_if_ready", i), 32'(bus.if_req_ready), 32'(!el));
            chk($sformatf("arb%0d_rd_addr", i), bus.mem_rd_addr, el ? 32'h80 : 32'h40);
            if (i > 0) begin
                chk($sformatf("arb%0d_ls_rsp", i), 32'(bus.ls_rsp_valid), 32'(pl));
                chk($sformatf("arb%0d_if_rsp", i), 32'(bus.if_rsp_valid), 32'(!pl));
                chk($sformatf("arb%0d_ls_data", i), bus.ls_rsp_data, pl ? 32'h83828180 : 32'd0);
                chk($sformatf("arb%0d_if_data", i), bus.if_rsp_data, pl ? 32'd0 : 32'h43424140);
            end
            tick();
        end
        idle(); #3;
        chk("arb_last_if_rsp", 32'(bus.if_rsp_valid), 32'd1);
        chk("arb_last_ls_rsp", 32'(bus.ls_rsp_valid), 32'd0);
        tick();
        drive(1'b1, 32'h20, 1'b1, 1'b1, 2'd1, 32'h20, 32'hAABBCCDD); #3;
        chk("st_ls_ready", 32'(bus.ls_req_ready), 32'd1);
        chk("st_if_ready", 32'(bus.if_req_ready), 32'd1);
        chk("st_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("st_wr_addr", bus.mem_wr_addr, 32'h20);
        chk("st_wr_data", bus.mem_wr_data, 32'hAABBCCDD);
        chk("st_rd_addr", bus.mem_rd_addr, 32'h20);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 32'h20, 32'd0); #3;
        chk("st_fetch_old", bus.if_rsp_data, 32'h23222120);
        chk("st_rsp_valid", 32'(bus.ls_rsp_valid), 32'd1);
        chk("st_rsp_data", bus.ls_rsp_data, 32'd0);
        chk("ld_ready", 32'(bus.ls_req_ready), 32'd1);
        chk("ld_no_wr", 32'(bus.mem_wr), 32'd0);
        tick(); idle(); #3;
        chk("ld_rsp_valid", 32'(bus.ls_rsp_valid), 32'd1);
        chk("ld_rsp_data", bus.ls_rsp_data, 32'h232221DD);
        tick();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0); #3;
        chk("fl_a_ready", 32'(bus.if_req_ready), 32'd1);
        tick();
        drive(1'b1, 32'h30, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        bus.if_flush = 1'b1; #3;
        chk("fl_b_ready", 32'(bus.if_req_ready), 32'd1);
        chk("fl_b_rsp", 32'(bus.if_rsp_valid), 32'd0);
        chk("fl_b_data", bus.if_rsp_data, 32'd0);
        tick();
        idle();
        bus.if_flush = 1'b0; #3;
        chk("fl_c_rsp", 32'(bus.if_rsp_valid), 32'd1);
        chk("fl_c_data", bus.if_rsp_data, 32'h33323130);
        tick();
        begin
            bit fv [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            bit eg [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 6; i++) begin
                drive(fv[i], 32'h40, 1'b1, 1'b0, 2'd0, 32'h80, 32'd0); #3;
                chk($sformatf("hold%0d_ls_ready", i), 32'(bus.ls_req_ready), 32'(eg[i]));
                chk($sformatf("hold%0d_if_ready", i), 32'(bus.if_req_ready), 32'(!eg[i]));
                tick();
            end
        end
        idle(); tick();
        contend(); tick();
        contend(); #3;
        chk("rs_pre_ls_ready", 32'(bus.ls_req_ready), 32'd1);
        tick();
        rst_n = 1'b0; #3;
        chk("rs_ls_rsp", 32'(bus.ls_rsp_valid), 32'd0);
        chk("rs_ls_data", bus.ls_rsp_data, 32'd0);
        chk("rs_ls_ready", 32'(bus.ls_req_ready), 32'd0);
        chk("rs_if_ready", 32'(bus.if_req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            contend(); #3;
            chk($sformatf("post%0d_ls_ready", i), 32'(bus.ls_req_ready), 32'(i != 4));
            chk($sformatf("post%0d_if_ready", i), 32'(bus.if_req_ready), 32'(i == 4));
            if (i == 0) chk("post_ls_rsp", 32'(bus.ls_rsp_valid), 32'd0);
            tick();
        end
        idle(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive contended cycles the fetch port may lose before it is granted ahead of the load/store port (range 1..15).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_req_valid  in  1  fetch read request.
REQ-005 if_req_ready  out  1  fetch request accepted this cycle (combinational).
REQ-006 if_req_addr  in  32  fetch byte address.
REQ-007 if_flush  in  1  discard the fetch response due this cycle.
REQ-008 if_rsp_valid  out  1  fetch read data valid.
REQ-009 if_rsp_data  out  32  fetch read data.
REQ-010 ls_req_valid  in  1  load/store request.
REQ-011 ls_req_ready  out  1  load/store request accepted this cycle (combinational).
REQ-012 ls_req_we  in  1  1 = store, 0 = load.
REQ-013 ls_req_size  in  2  store length: 0 none, 1 = 1 byte, 2 = 2 bytes, 3 = 4 bytes.
REQ-014 ls_req_addr  in  32  load/store byte address.
REQ-015 ls_req_wdata  in  32  store data, little-endian byte lanes.
REQ-016 ls_rsp_valid  out  1  load/store completion.
REQ-017 ls_rsp_data  out  32  load data; 0 for stores.
REQ-018 mem_rd_addr  out  32  memory read address; memory returns 4 bytes one cycle later.
REQ-019 mem_rd_data  in  32  memory read data.
REQ-020 mem_wr  out  2  memory write length, same encoding as ls_req_size.
REQ-021 mem_wr_addr  out  32  memory write address.
REQ-022 mem_wr_data  out  32  memory write data.

Function
REQ-023 A request is accepted in a cycle where valid && ready are both high; each port has at most one acceptance per cycle.
REQ-024 Stores never contend: ls_req_ready = 1 whenever ls_req_valid && ls_req_we; in that cycle mem_wr = ls_req_size, mem_wr_addr = ls_req_addr, mem_wr_data = ls_req_wdata.
REQ-025 mem_wr = 0 in every cycle without an accepted store.
REQ-026 The read port goes to exactly one of {fetch, load} per cycle; with only one requester, that requester is granted.
REQ-027 Contention (if_req_valid && load valid): load wins unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
REQ-028 Starvation counter: increments on each contended cycle fetch loses; clears to 0 on any fetch acceptance; saturates at STARVE_LIMIT.
REQ-029 A store and a fetch read are accepted in the same cycle; the counter is unchanged unless fetch is accepted.
REQ-030 mem_rd_addr = ls_req_addr when load granted, else if_req_addr.
REQ-031 Read latency is exactly 1 cycle: a read accepted in cycle N asserts its rsp_valid for one cycle in N+1 with rsp_data = mem_rd_data in N+1.
REQ-032 A store accepted in cycle N asserts ls_rsp_valid in N+1 with ls_rsp_data = 0.
REQ-033 Same-cycle fetch read and store to overlapping bytes: fetch returns pre-store contents; no forwarding.
REQ-034 if_flush high in cycle N forces if_rsp_valid = 0 in N; a fetch accepted in N is unaffected and responds in N+1.
REQ-035 if_rsp_data and ls_rsp_data are 0 whenever their rsp_valid is 0.
REQ-036 No backpressure on responses; requesters always sink them.

Reset
REQ-037 While rst_n = 0: if_rsp_valid = 0, ls_rsp_valid = 0, starvation counter = 0, in-flight responses discarded; mem_wr = 0 and both req_ready = 0.
REQ-038 The first acceptance is possible in the first posedge after rst_n deasserts.

Verification
REQ-039 Fetch-only read at 0x10, memory byte pattern 0x44332211 -> if_req_ready = 1, if_rsp_valid in N+1, if_rsp_data = 0x44332211.
REQ-040 Fetch and load both valid every cycle, STARVE_LIMIT = 4 -> grants L,L,L,L,F repeating; each rsp_valid exactly one cycle after its grant.
REQ-041 Store size 1 to 0x20 data 0xAABBCCDD plus same-cycle fetch of 0x20 -> mem_wr = 1, fetch returns old word, later load of 0x20 returns low byte 0xDD.
REQ-042 Fetch accepted in N, if_flush in N+1 with new fetch in N+1 -> no if_rsp_valid in N+1, if_rsp_valid in N+2 with new data.
REQ-043 rst_n low during N+1 after a load accepted in N -> ls_rsp_valid stays 0, counter 0; normal arbitration resumes after release.
